fma_align_pipe: RTL and testbench
=================================

// Module: fma_align_pipe
// PURPOSE
//  Pipelined addend-alignment stage directly downstream of FMA exponent addition.
//  Consumes product exponent Pe and addend Z (Ze, Zm, ZZero). Produces aligned addend
//  significand Am, alignment sticky ASticky and kill classification for the FMA adder.
//  Two register stages with valid/ready backpressure and flush.
// PARAMETERS
//  P    cvw_t (default: core config)  supplies NE, NF, BIAS
//  AW   3*P.NF+4 (localparam)         aligned-addend width
//  CW   P.NE+2 (localparam)           shift-count width, two's complement
// PORTS
//  clk       in   1     clock
//  reset     in   1     synchronous, active-high
//  FlushE    in   1     drop all in-flight ops
//  InValid   in   1     upstream op valid
//  InReady   out  1     stage can accept this cycle
//  Pe        in   NE+2  product exponent, two's complement, 0 when product zero
//  PZero     in   1     product is zero (XZero|YZero)
//  Ze        in   NE    addend biased exponent
//  Zm        in   NF+1  addend significand incl. leading bit
//  ZZero     in   1     addend is zero
//  OutValid  out  1     result valid
//  OutReady  in   1     downstream accepts
//  Am        out  AW    aligned addend significand
//  ASticky   out  1     OR of all bits shifted below Am, or killed operand nonzero
//  KillProd  out  1     product negligible vs addend
//  KillZ     out  1     addend negligible vs product
// BEHAVIOUR
//  Reset: S1Valid=S2Valid=0; OutValid=0; Am=0; ASticky=KillProd=KillZ=0; InReady=1.
//  S1 (register after compute): ACnt = Pe - {2'b0,Ze} + (NF+2), CW bits, signed.
//   Class: ACnt<0 -> KILLPROD; ACnt>AW+1 -> KILLZ; else NORM. Register ACnt, class, Zm, ZZero, PZero.
//  S2 (register after compute): ZmPre = {Zm,(2NF+3)'0} (AW bits).
//   NORM:     Shifted = {ZmPre,AW'0} >> ACnt (2AW bits); Am=Shifted[2AW-1:AW]; ASticky=|Shifted[AW-1:0].
//   KILLPROD: Am=ZmPre; ASticky=~PZero; KillProd=1.
//   KILLZ:    Am=0; ASticky=~ZZero; KillZ=1.
//   ZZero with NORM: Am=0, ASticky=0 (falls out of shift of zero Zm).
//  Latency: 2 cycles input accept -> OutValid with no backpressure; throughput 1/cycle.
//  Handshake: S2Load = ~S2Valid | OutReady; S1Load = ~S1Valid | S2Load; InReady = S1Load.
//   Transfer in on InValid&InReady; out on OutValid&OutReady.
//   OutValid&~OutReady: Am/ASticky/KillProd/KillZ held stable; S1 holds if S2 full.
//   Simultaneous out-accept and in-accept with both stages full: both stages advance, no bubble.
//  FlushE: next cycle S1Valid=S2Valid=0; an InValid in same cycle is dropped; data regs may retain
//   values but OutValid=0. Flush dominates handshake. Reset dominates flush.
//  Reset mid-operation: all in-flight ops discarded, outputs return to reset values.
//  No combinational path InValid->OutValid; InReady depends only on OutReady and valid regs.
// STRUCTURE
//  cvw package: fma_align_class_t enum {ALIGN_NORM, ALIGN_KILLPROD, ALIGN_KILLZ}.
//  Sub-module fma_align_shift: combinational NORM shifter (ZmPre, ACnt -> Am, ASticky);
//   top holds ACnt/class logic, both pipeline registers and the handshake.
// TESTING (double: NE=11, NF=52, BIAS=1023, AW=160)
//  Pe=1023, Ze=1023, Zm=1<<52 -> after 2 cycles OutValid, ACnt=54, Am has single 1 at bit 105, ASticky=0.
//  Pe=1023, Ze=1083 -> ACnt=-6, KillProd=1, Am=Zm<<107, ASticky=1; repeat PZero=1 -> ASticky=0.
//  Pe=1023, Ze=1, ZZero=0 -> ACnt=1076, KillZ=1, Am=0, ASticky=1.
//  Pe=1023, Ze=967, Zm=all ones -> ACnt=110, Am bits[49:0]=all ones, ASticky=1.
//  Back-to-back 4 ops, OutReady low 3 cycles -> InReady low after 2 accepted, outputs stable, order kept.
//  FlushE with both stages full plus InValid -> next cycle OutValid=0, no op emitted; reset likewise.

Source files
------------

// File: rtl/fma_align_pipe_pkg.sv
// Shared types and default double-precision format constants for the FMA
// addend-alignment pipeline.
package fma_align_pipe_pkg;

  localparam int PKG_NE   = 11;
  localparam int PKG_NF   = 52;
  localparam int PKG_BIAS = 1023;

  typedef enum logic [1:0] {
    ALIGN_NORM     = 2'd0,
    ALIGN_KILLPROD = 2'd1,
    ALIGN_KILLZ    = 2'd2
  } fma_align_class_t;

  // A negative count puts the addend entirely above the product; a count
  // past aw+1 pushes every addend bit below the sticky window.
  function automatic fma_align_class_t align_classify(input int acnt, input int aw);
    fma_align_class_t cls;
    if (acnt < 0) begin
      cls = ALIGN_KILLPROD;
    end else if (acnt > aw + 1) begin
      cls = ALIGN_KILLZ;
    end else begin
      cls = ALIGN_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fma_align_shift.sv
// Combinational right shifter for the in-range alignment case: positions the
// pre-shifted addend against the product and ORs everything shifted out.
module fma_align_shift #(
  parameter int AW = 160,
  parameter int CW = 13
) (
  input  logic [AW-1:0] zm_pre_i,
  input  logic [CW-1:0] acnt_i,
  output logic [AW-1:0] am_o,
  output logic          sticky_o
);

  logic [2*AW-1:0] shifted;

  assign shifted  = {zm_pre_i, {AW{1'b0}}} >> acnt_i;
  assign am_o     = shifted[2*AW-1:AW];
  assign sticky_o = |shifted[AW-1:0];

endmodule

// File: rtl/fma_align_pipe.sv
// Two-stage addend alignment for the FMA: stage 1 registers the shift count and
// kill class, stage 2 registers the aligned significand, sticky and kill flags.
module fma_align_pipe
  import fma_align_pipe_pkg::*;
#(
  parameter  int NE = PKG_NE,
  parameter  int NF = PKG_NF,
  localparam int AW = 3*NF + 4,
  localparam int CW = NE + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          FlushE,
  input  logic          InValid,
  output logic          InReady,
  input  logic [NE+1:0] Pe,
  input  logic          PZero,
  input  logic [NE-1:0] Ze,
  input  logic [NF:0]   Zm,
  input  logic          ZZero,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [AW-1:0] Am,
  output logic          ASticky,
  output logic          KillProd,
  output logic          KillZ
);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high at the clock edge; valid, once raised, holds with stable data until
  // that transfer, and ready never depends on the same-cycle valid input.
  logic s2_load;
  logic s1_load;

  // Stage 1 state
  logic                  s1_valid_q, s1_valid_d;
  logic signed [CW-1:0]  s1_acnt_q,  s1_acnt_d;
  fma_align_class_t      s1_class_q, s1_class_d;
  logic [NF:0]           s1_zm_q;
  logic                  s1_zzero_q;
  logic                  s1_pzero_q;

  // Stage 2 state
  logic                  s2_valid_q,  s2_valid_d;
  logic [AW-1:0]         s2_am_q,     s2_am_d;
  logic                  s2_sticky_q, s2_sticky_d;
  logic                  s2_kprod_q,  s2_kprod_d;
  logic                  s2_kz_q,     s2_kz_d;

  logic [AW-1:0]         zm_pre;
  logic [AW-1:0]         norm_am;
  logic                  norm_sticky;

  assign s2_load = ~s2_valid_q | OutReady;
  assign s1_load = ~s1_valid_q | s2_load;
  assign InReady = s1_load;

  // Valid tracking; flush empties both stages and swallows a same-cycle input.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (FlushE) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_load) s1_valid_d = InValid;
      if (s2_load) s2_valid_d = s1_valid_q;
    end
  end

  // Stage 1 compute: count of right-shift positions relative to the product.
  always_comb begin
    s1_acnt_d  = $signed(Pe) - $signed({2'b00, Ze}) + CW'(NF + 2);
    s1_class_d = align_classify(int'(s1_acnt_d), AW);
  end

  assign zm_pre = {s1_zm_q, {(2*NF+3){1'b0}}};

  fma_align_shift #(
    .AW(AW),
    .CW(CW)
  ) u_shift (
    .zm_pre_i (zm_pre),
    .acnt_i   (s1_acnt_q),
    .am_o     (norm_am),
    .sticky_o (norm_sticky)
  );

  // Stage 2 compute; a killed operand still contributes to sticky if nonzero.
  always_comb begin
    s2_am_d     = '0;
    s2_sticky_d = 1'b0;
    s2_kprod_d  = 1'b0;
    s2_kz_d     = 1'b0;
    case (s1_class_q)
      ALIGN_KILLPROD: begin
        s2_am_d     = zm_pre;
        s2_sticky_d = ~s1_pzero_q;
        s2_kprod_d  = 1'b1;
      end
      ALIGN_KILLZ: begin
        s2_sticky_d = ~s1_zzero_q;
        s2_kz_d     = 1'b1;
      end
      default: begin
        if (!s1_zzero_q) begin
          s2_am_d     = norm_am;
          s2_sticky_d = norm_sticky;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_acnt_q   <= '0;
      s1_class_q  <= ALIGN_NORM;
      s1_zm_q     <= '0;
      s1_zzero_q  <= 1'b0;
      s1_pzero_q  <= 1'b0;
      s2_am_q     <= '0;
      s2_sticky_q <= 1'b0;
      s2_kprod_q  <= 1'b0;
      s2_kz_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load && InValid) begin
        s1_acnt_q  <= s1_acnt_d;
        s1_class_q <= s1_class_d;
        s1_zm_q    <= Zm;
        s1_zzero_q <= ZZero;
        s1_pzero_q <= PZero;
      end
      if (s2_load && s1_valid_q) begin
        s2_am_q     <= s2_am_d;
        s2_sticky_q <= s2_sticky_d;
        s2_kprod_q  <= s2_kprod_d;
        s2_kz_q     <= s2_kz_d;
      end
    end
  end

  assign OutValid = s2_valid_q;
  assign Am       = s2_am_q;
  assign ASticky  = s2_sticky_q;
  assign KillProd = s2_kprod_q;
  assign KillZ    = s2_kz_q;

endmodule

// File: tb/tb_fma_align_pipe.sv
// Bench for fma_align_pipe in double format: directed alignment cases,
// backpressure, flush/reset, then randomized traffic against a reference model.
module tb_fma_align_pipe;

  localparam int NE = 11;
  localparam int NF = 52;
  localparam int AW = 3*NF + 4;
  localparam int RW = AW + 3;

  logic          clk;
  logic          reset;
  logic          FlushE;
  logic          InValid;
  logic          InReady;
  logic [NE+1:0] Pe;
  logic          PZero;
  logic [NE-1:0] Ze;
  logic [NF:0]   Zm;
  logic          ZZero;
  logic          OutValid;
  logic          OutReady;
  logic [AW-1:0] Am;
  logic          ASticky;
  logic          KillProd;
  logic          KillZ;

  fma_align_pipe #(.NE(NE), .NF(NF)) dut (
    .clk      (clk),
    .reset    (reset),
    .FlushE   (FlushE),
    .InValid  (InValid),
    .InReady  (InReady),
    .Pe       (Pe),
    .PZero    (PZero),
    .Ze       (Ze),
    .Zm       (Zm),
    .ZZero    (ZZero),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Am       (Am),
    .ASticky  (ASticky),
    .KillProd (KillProd),
    .KillZ    (KillZ)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur_exp;
  logic [RW-1:0] held;
  bit            held_v;
  bit            last_in_fire;
  int            chk_cnt;
  int            pass_cnt;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: each addend bit i sits at weight 2NF+3+i before alignment and
  // moves down by the alignment count; bits that fall below 0 feed sticky.
  function automatic logic [RW-1:0] ref_model(input int pe, input int ze, input logic [NF:0] zm,
                                              input bit zz, input bit pz);
    int            acnt;
    int            pos;
    logic [AW-1:0] am;
    bit            st;
    bit            kp;
    bit            kz;
    acnt = pe - ze + NF + 2;
    am   = '0;
    st   = 1'b0;
    kp   = 1'b0;
    kz   = 1'b0;
    if (acnt < 0) begin
      kp = 1'b1;
      st = !pz;
      for (int i = 0; i <= NF; i++) am[2*NF+3+i] = zm[i];
    end else if (acnt > AW + 1) begin
      kz = 1'b1;
      st = !zz;
    end else if (!zz) begin
      for (int i = 0; i <= NF; i++) begin
        if (zm[i]) begin
          pos = 2*NF + 3 + i - acnt;
          if (pos >= 0) am[pos] = 1'b1;
          else st = 1'b1;
        end
      end
    end
    return {am, st, kp, kz};
  endfunction

  // Driver tasks
  task automatic drive_op(input int pe, input int ze, input logic [NF:0] zm, input bit zz, input bit pz);
    Pe      = pe[NE+1:0];
    Ze      = ze[NE-1:0];
    Zm      = zm;
    ZZero   = zz;
    PZero   = pz;
    InValid = 1'b1;
    cur_exp = ref_model(pe, ze, zm, zz, pz);
  endtask

  task automatic gen_op();
    int            ze;
    int            pe;
    int            delta;
    int            sel;
    logic [63:0]   r;
    logic [NF:0]   zm;
    bit            zz;
    bit            pz;
    ze  = int'($urandom_range(1, 2046));
    sel = int'($urandom_range(0, 9));
    if (sel < 7)       delta = int'($urandom_range(0, AW + 1));
    else if (sel == 7) delta = -int'($urandom_range(1, 60));
    else if (sel == 8) delta = AW + 2 + int'($urandom_range(0, 300));
    else               delta = (int'($urandom_range(0, 1)) == 0) ? 0 : AW + 1;
    pe = ze - (NF + 2) + delta;
    r  = {$urandom(), $urandom()};
    zm = {1'b1, r[NF-1:0]};
    zz = ($urandom_range(0, 15) == 0);
    if (zz) zm = '0;
    pz = ($urandom_range(0, 7) == 0);
    if (pz) pe = 0;
    drive_op(pe, ze, zm, zz, pz);
  endtask

  // One cycle: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    last_in_fire = 1'b0;
    if (!reset) begin
      check("inready", RW'(InReady), RW'(!(exp_q.size() == 2 && !OutReady)));
      if (held_v) begin
        check("hold_valid", RW'(OutValid), RW'(1));
        check("hold_data", {Am, ASticky, KillProd, KillZ}, held);
      end
      if (OutValid && OutReady) begin
        check("out_expected", RW'(exp_q.size() != 0), RW'(1));
        if (exp_q.size() != 0) check("out_data", {Am, ASticky, KillProd, KillZ}, exp_q.pop_front());
      end
      held_v = OutValid && !OutReady && !FlushE;
      held   = {Am, ASticky, KillProd, KillZ};
      if (InValid && InReady && !FlushE) begin
        exp_q.push_back(cur_exp);
        last_in_fire = 1'b1;
      end
      if (FlushE) exp_q.delete();
    end else begin
      exp_q.delete();
      held_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int pe, input int ze, input logic [NF:0] zm, input bit zz, input bit pz);
    drive_op(pe, ze, zm, zz, pz);
    tick();
    InValid = 1'b0;
    check("lat_not_early", RW'(OutValid), RW'(0));
    tick();
    check("lat_valid", RW'(OutValid), RW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {RW'(OutValid), RW'(InReady)}, {RW'(0), RW'(1)});
    check(tag, {Am, ASticky, KillProd, KillZ}, RW'(0));
  endtask

  logic [AW-1:0] v;
  logic [NF:0]   zm_t;
  int            sent;
  int            cyc;

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    held_v   = 1'b0;
    reset    = 1'b1;
    FlushE   = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    Pe = '0; PZero = 1'b0; Ze = '0; Zm = '0; ZZero = 1'b0;
    cur_exp = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset_state");

    // In-range alignment: single leading one lands at bit 105.
    run_one(1023, 1023, 53'(1) << 52, 1'b0, 1'b0);
    v = '0; v[105] = 1'b1;
    check("ex1_am", {Am, ASticky, KillProd, KillZ}, {v, 3'b000});
    tick();

    // Addend dominates: product killed.
    zm_t = {1'b1, 52'h5_A5A5_1234_0F0F};
    run_one(1023, 1083, zm_t, 1'b0, 1'b0);
    v = '0; v[AW-1 -: NF+1] = zm_t;
    check("ex2_killprod", {Am, ASticky, KillProd, KillZ}, {v, 3'b110});
    tick();
    run_one(1023, 1083, zm_t, 1'b0, 1'b1);
    check("ex2_killprod_pzero", {Am, ASticky, KillProd, KillZ}, {v, 3'b010});
    tick();

    // Product dominates: addend killed.
    run_one(1023, 1, zm_t, 1'b0, 1'b0);
    check("ex3_killz", {Am, ASticky, KillProd, KillZ}, {AW'(0), 3'b101});
    tick();

    // Deep shift with all-ones addend.
    run_one(1023, 967, '1, 1'b0, 1'b0);
    v = '0; v[49:0] = '1;
    check("ex4_deep", {Am, ASticky, KillProd, KillZ}, {v, 3'b100});
    tick();

    // Class boundaries: counts 0, AW+1, AW+2, -1 and a zero addend in range.
    run_one(1000 - (NF + 2), 1000, zm_t, 1'b0, 1'b0);
    check("acnt_0", {Am, ASticky, KillProd, KillZ}, {zm_t, 107'd0, 3'b000});
    tick();
    run_one(1000 - (NF + 2) + AW + 1, 1000, zm_t, 1'b0, 1'b0);
    check("acnt_max_norm", {Am, ASticky, KillProd, KillZ}, {AW'(0), 3'b100});
    tick();
    run_one(1000 - (NF + 2) + AW + 2, 1000, zm_t, 1'b0, 1'b0);
    check("acnt_first_killz", {Am, ASticky, KillProd, KillZ}, {AW'(0), 3'b101});
    tick();
    run_one(1000 - (NF + 2) - 1, 1000, zm_t, 1'b0, 1'b0);
    check("acnt_neg1", {KillProd, KillZ}, 2'b10);
    tick();
    run_one(1000, 1000, '0, 1'b1, 1'b0);
    check("zzero_norm", {Am, ASticky, KillProd, KillZ}, RW'(0));
    tick();

    // Backpressure: four ops back to back, sink stalled for three cycles.
    sent = 0;
    cyc  = 0;
    last_in_fire = 1'b0;
    while ((sent < 4 || exp_q.size() != 0) && cyc < 40) begin
      OutReady = (cyc >= 3);
      if (!(InValid && !last_in_fire)) begin
        if (sent < 4) drive_op(900 + 7 * sent, 950, zm_t ^ 53'(sent), 1'b0, 1'b0);
        else InValid = 1'b0;
      end
      if (cyc == 2) check("bp_inready_low", RW'(InReady), RW'(0));
      tick();
      if (last_in_fire) sent++;
      cyc++;
    end
    InValid = 1'b0;
    check("bp_done", RW'(cyc < 40), RW'(1));

    // Flush with both stages full and a new input offered.
    OutReady = 1'b0;
    drive_op(1023, 1023, zm_t, 1'b0, 1'b0); tick();
    drive_op(1023, 1000, zm_t, 1'b0, 1'b0); tick();
    drive_op(1023, 990, zm_t, 1'b0, 1'b0);
    FlushE = 1'b1;
    tick();
    FlushE   = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    check("flush_outvalid", RW'(OutValid), RW'(0));
    repeat (3) tick();
    check("flush_no_emit", RW'(OutValid), RW'(0));

    // Reset mid-operation.
    OutReady = 1'b0;
    drive_op(1023, 1023, zm_t, 1'b0, 1'b0); tick();
    drive_op(1023, 1, zm_t, 1'b0, 1'b0); tick();
    drive_op(1023, 1083, zm_t, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    check_reset_outputs("reset_mid_op");
    repeat (3) tick();
    check("reset_no_emit", RW'(OutValid), RW'(0));

    // Randomized traffic with random sink stalls.
    sent = 0;
    cyc  = 0;
    last_in_fire = 1'b0;
    while ((sent < 300 || exp_q.size() != 0) && cyc < 5000) begin
      OutReady = ($urandom_range(0, 3) != 0);
      if (!(InValid && !last_in_fire)) begin
        if (sent < 300 && $urandom_range(0, 4) != 0) gen_op();
        else InValid = 1'b0;
      end
      tick();
      if (last_in_fire) sent++;
      cyc++;
    end
    InValid = 1'b0;
    check("rand_done", RW'(cyc < 5000), RW'(1));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
